// File: rtl/hazard_stall_controller_pkg.sv
// Purpose : shared types and constants for the pipeline hazard/stall controller.
// Latency : n/a (types only).
// Backpress: n/a.
package hazard_stall_controller_pkg;

  // Destination-register shadow of one in-flight pipeline stage.
  typedef struct packed {
    logic       valid;    // stage holds an instruction that writes dest
    logic [4:0] dest;     // destination register number
    logic       is_load;  // producer is a load (value only after MEM)
  } slot_t;

  // Multiply/divide unit occupancy.
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A slot only creates a dependency on a real register it is writing.
  function automatic logic slot_match(slot_t s, logic [4:0] r);
    return s.valid && (s.dest == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Purpose : 3-entry shift of in-flight destination registers (EXE, MEM, WB) with rs/rt match.
// Latency : matches are combinational from the registered slots; slots advance one stage per cycle.
// Backpress: hold freezes all slots; bubble loads an invalid entry into EXE instead of the ID instruction.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   hold, bubble               freeze all slots / insert an empty EXE slot
//   in_dest/in_reg_write/in_load  ID instruction entering EXE
//   rs/rt, uses_rs/uses_rt     ID operands to check against the slots
//   exe_hit, exe_is_load       a used operand matches the EXE slot; its producer kind
//   mem_hit, mem_is_load       same for the MEM slot
module hazard_slot_pipe
  import hazard_stall_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       bubble,
  input  logic [4:0] in_dest,
  input  logic       in_reg_write,
  input  logic       in_load,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  output logic       exe_hit,
  output logic       exe_is_load,
  output logic       mem_hit,
  output logic       mem_is_load
);

  slot_t exe_q, exe_d;
  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      if (bubble) begin
        exe_d = '0;
      end else begin
        // Writes to $zero are architecturally discarded, so never track them.
        exe_d.valid   = in_reg_write && (in_dest != REG_ZERO);
        exe_d.dest    = in_dest;
        exe_d.is_load = in_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  always_comb begin
    exe_hit     = (uses_rs && slot_match(exe_q, rs)) || (uses_rt && slot_match(exe_q, rt));
    mem_hit     = (uses_rs && slot_match(mem_q, rs)) || (uses_rt && slot_match(mem_q, rt));
    exe_is_load = exe_q.is_load;
    mem_is_load = mem_q.is_load;
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Purpose : stall/bubble/flush/freeze sequencer for the 5-stage MIPS pipeline.
// Latency : all control outputs are combinational from ID inputs and registered hazard state.
// Backpress: mem_busy freezes everything; a stall holds PC/IF-ID and bubbles ID/EXE; flush only when not stalled.
//
// Ports:
//   CLK, RESET            clock, synchronous active-low reset
//   id_*                  decoded fields of the instruction currently in ID
//   mem_busy              data memory not ready
//   pc_enable, if_id_enable, id_exe_bubble, if_id_flush, pipe_freeze  pipeline controls
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 4,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dest,
  input  logic       id_reg_write,
  input  logic       id_load,
  input  logic       id_needs_early,
  input  logic       id_branch_taken,
  input  logic       id_muldiv_start,
  input  logic       id_hilo_read,
  input  logic       mem_busy,
  output logic       pc_enable,
  output logic       if_id_enable,
  output logic       id_exe_bubble,
  output logic       if_id_flush,
  output logic       pipe_freeze
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MULDIV_LATENCY);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic exe_hit, exe_is_load, mem_hit, mem_is_load;
  logic load_use, early_haz, md_haz, stall;

  md_state_e        md_state_q, md_state_d;
  logic [CNT_W-1:0] md_cnt_q,   md_cnt_d;

  hazard_slot_pipe u_slot_pipe (
    .clk          (CLK),
    .rst_n        (RESET),
    .hold         (mem_busy),
    .bubble       (stall),
    .in_dest      (id_dest),
    .in_reg_write (id_reg_write),
    .in_load      (id_load),
    .rs           (id_rs),
    .rt           (id_rt),
    .uses_rs      (id_uses_rs),
    .uses_rt      (id_uses_rt),
    .exe_hit      (exe_hit),
    .exe_is_load  (exe_is_load),
    .mem_hit      (mem_hit),
    .mem_is_load  (mem_is_load)
  );

  // Hazard terms. Branch/JR operands are read in ID, so they cannot use the
  // EXE-stage forwarding path and wait for any EXE producer and for a load
  // still in MEM; ordinary consumers only wait for a load in EXE.
  always_comb begin
    load_use  = exe_hit && exe_is_load && !id_needs_early;
    early_haz = id_needs_early && (exe_hit || (mem_hit && mem_is_load));
    md_haz    = (id_hilo_read || id_muldiv_start) && (md_state_q == MD_BUSY);
    stall     = load_use || early_haz || md_haz;
  end

  // Mul/div occupancy: counts EXE cycles remaining, pausing while frozen.
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      MD_IDLE: begin
        if (id_muldiv_start && !stall && !mem_busy) begin
          md_state_d = MD_BUSY;
          md_cnt_d   = LAT_CNT;
        end
      end
      MD_BUSY: begin
        if (!mem_busy) begin
          if (md_cnt_q == ONE_CNT) begin
            md_state_d = MD_IDLE;
            md_cnt_d   = '0;
          end else begin
            md_cnt_d = md_cnt_q - ONE_CNT;
          end
        end
      end
      default: begin
        md_state_d = MD_IDLE;
        md_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= '0;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

  // Priority: memory freeze over stall, stall over flush. During reset the
  // front end is held and ID/EXE is filled with NOPs.
  always_comb begin
    pc_enable     = 1'b0;
    if_id_enable  = 1'b0;
    id_exe_bubble = 1'b1;
    if_id_flush   = 1'b0;
    pipe_freeze   = 1'b0;
    if (RESET) begin
      pipe_freeze   = mem_busy;
      pc_enable     = !mem_busy && !stall;
      if_id_enable  = !mem_busy && !stall;
      id_exe_bubble = !mem_busy && stall;
      if_id_flush   = !mem_busy && !stall && id_branch_taken;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;
  import hazard_stall_controller_pkg::*;

  localparam int LAT = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_load, id_needs_early;
  logic       id_branch_taken, id_muldiv_start, id_hilo_read, mem_busy;
  logic       pc_enable, if_id_enable, id_exe_bubble, if_id_flush, pipe_freeze;
  logic [4:0] outs;

  always #5 CLK = ~CLK;

  hazard_stall_controller #(.MULDIV_LATENCY(LAT), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_load(id_load),
    .id_needs_early(id_needs_early), .id_branch_taken(id_branch_taken),
    .id_muldiv_start(id_muldiv_start), .id_hilo_read(id_hilo_read), .mem_busy(mem_busy),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_exe_bubble(id_exe_bubble),
    .if_id_flush(if_id_flush), .pipe_freeze(pipe_freeze)
  );

  assign outs = {pc_enable, if_id_enable, id_exe_bubble, if_id_flush, pipe_freeze};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the last three instructions that actually left ID
  // (index 0 = issued one cycle ago), plus cycles of mul/div work left.
  slot_t      hist[3];
  int         md_left;
  logic       m_stall;
  logic [4:0] m_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic reads(int age, logic [4:0] r, logic used);
    return used && (r != 5'd0) && hist[age].valid && (hist[age].dest == r);
  endfunction

  task automatic model_eval();
    logic dep0, dep1;
    dep0 = reads(0, id_rs, id_uses_rs) || reads(0, id_rt, id_uses_rt);
    dep1 = reads(1, id_rs, id_uses_rs) || reads(1, id_rt, id_uses_rt);
    m_stall = (dep0 && hist[0].is_load && !id_needs_early)
           || (id_needs_early && (dep0 || (dep1 && hist[1].is_load)))
           || ((id_hilo_read || id_muldiv_start) && md_left > 0);
    if (!RESET)        m_out = 5'b00100;
    else if (mem_busy) m_out = 5'b00001;
    else if (m_stall)  m_out = 5'b00100;
    else               m_out = {3'b110, id_branch_taken, 1'b0};
  endtask

  task automatic model_update();
    if (!RESET) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      md_left = 0;
    end else if (!mem_busy) begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (m_stall) hist[0] = '0;
      else hist[0] = '{valid: id_reg_write && id_dest != 5'd0, dest: id_dest, is_load: id_load};
      if (md_left > 0) md_left--;
      else if (id_muldiv_start && !m_stall) md_left = LAT;
    end
  endtask

  task automatic nop();
    id_rs = 0; id_rt = 0; id_dest = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0; id_load = 0;
    id_needs_early = 0; id_branch_taken = 0; id_muldiv_start = 0; id_hilo_read = 0;
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    nop(); id_rs = s; id_rt = t; id_uses_rs = 1; id_uses_rt = 1; id_dest = d; id_reg_write = 1;
  endtask

  task automatic lw(input logic [4:0] d, input logic [4:0] base);
    nop(); id_rs = base; id_uses_rs = 1; id_rt = d; id_dest = d; id_reg_write = 1; id_load = 1;
  endtask

  task automatic beq(input logic [4:0] s, input logic [4:0] t, input logic tk);
    nop(); id_rs = s; id_rt = t; id_uses_rs = 1; id_uses_rt = 1; id_needs_early = 1; id_branch_taken = tk;
  endtask

  task automatic mult(input logic [4:0] s, input logic [4:0] t);
    nop(); id_rs = s; id_rt = t; id_uses_rs = 1; id_uses_rt = 1; id_muldiv_start = 1;
  endtask

  task automatic mflo(input logic [4:0] d);
    nop(); id_dest = d; id_reg_write = 1; id_hilo_read = 1;
  endtask

  // One clock with the current inputs, checking outputs against the model.
  task automatic step(input string tag);
    @(negedge CLK);
    model_eval();
    check(tag, 32'(outs), 32'(m_out));
    @(posedge CLK);
    model_update();
    #1;
  endtask

  // Hold the current ID instruction until it leaves ID; count bubbles seen.
  task automatic issue(input string tag, output int stalls, output logic flush_seen);
    logic done;
    done = 1'b0;
    stalls = 0;
    flush_seen = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      model_eval();
      check(tag, 32'(outs), 32'(m_out));
      if (id_exe_bubble) stalls++;
      flush_seen = if_id_flush;
      done = RESET && !mem_busy && !m_stall;
      @(posedge CLK);
      model_update();
      #1;
    end
    if (!done) check({tag, "_timeout"}, 32'(0), 32'(1));
    nop();
  endtask

  int   st;
  logic fl;

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '0;
    md_left = 0;
    nop();
    mem_busy = 0;
    RESET = 0;

    // Reset: outputs forced, state cleared.
    step("reset_outs");
    step("reset_outs");
    RESET = 1;
    check("reset_md_state", 32'(dut.md_state_q), 32'(MD_IDLE));
    check("reset_exe_slot", 32'(dut.u_slot_pipe.exe_q), 32'(0));
    step("idle");

    // Load-use: LW r5 ; ADD r6,r5,r1 -> one bubble, then ADD sits in EXE.
    lw(5, 1);      issue("lw_r5", st, fl);   check("lw_r5_stalls", 32'(st), 32'(0));
    alu(6, 5, 1);  issue("add_r6", st, fl);  check("load_use_stalls", 32'(st), 32'(1));
    check("load_use_exe_dest", 32'(dut.u_slot_pipe.exe_q.dest), 32'(6));
    check("load_use_exe_slot", 32'(dut.u_slot_pipe.exe_q), 32'(hist[0]));

    // ALU -> branch: one stall.
    alu(3, 1, 2);  issue("add_r3", st, fl);
    beq(3, 4, 0);  issue("beq_alu", st, fl);  check("alu_branch_stalls", 32'(st), 32'(1));

    // Load -> taken branch: two stalls, flush only when it finally issues.
    step("gap");
    lw(3, 2);      issue("lw_r3", st, fl);
    beq(3, 4, 1);  issue("beq_lw", st, fl);   check("load_branch_stalls", 32'(st), 32'(2));
    check("load_branch_flush", 32'(fl), 32'(1));

    // MULT then MFLO immediately: HI/LO busy for LAT cycles after issue.
    mult(1, 2);    issue("mult", st, fl);
    check("mult_busy", 32'(dut.md_state_q), 32'(MD_BUSY));
    check("mult_cnt", 32'(dut.md_cnt_q), 32'(LAT));
    mflo(2);       issue("mflo", st, fl);     check("mflo_stalls", 32'(st), 32'(LAT));
    check("mflo_md_idle", 32'(dut.md_state_q), 32'(MD_IDLE));

    // Freeze during a load-use stall with mul/div in progress.
    step("gap");
    mult(1, 2);    issue("mult2", st, fl);
    lw(5, 1);      issue("lw_r5b", st, fl);
    alu(6, 5, 1);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) step("freeze");
    check("freeze_exe_slot", 32'(dut.u_slot_pipe.exe_q), 32'(hist[0]));
    check("freeze_mem_slot", 32'(dut.u_slot_pipe.mem_q), 32'(hist[1]));
    check("freeze_md_cnt", 32'(dut.md_cnt_q), 32'(md_left));
    mem_busy = 0;
    alu(6, 5, 1);  issue("add_after_freeze", st, fl); check("freeze_resume_stalls", 32'(st), 32'(1));
    for (int i = 0; i < 4; i++) step("drain");

    // Register $zero never creates a hazard.
    lw(0, 1);      issue("lw_r0", st, fl);
    alu(1, 0, 0);  issue("add_r0", st, fl);   check("zero_stalls", 32'(st), 32'(0));

    // Reset in the middle of a mul/div.
    alu(7, 1, 2);  issue("add_r7", st, fl);
    mult(1, 2);    issue("mult3", st, fl);
    step("md_run");
    check("mid_md_cnt", 32'(dut.md_cnt_q), 32'(3));
    RESET = 0;
    step("mid_reset");
    RESET = 1;
    check("mid_reset_md_state", 32'(dut.md_state_q), 32'(MD_IDLE));
    check("mid_reset_md_cnt", 32'(dut.md_cnt_q), 32'(0));
    check("mid_reset_slots", 32'({dut.u_slot_pipe.exe_q.valid, dut.u_slot_pipe.mem_q.valid,
                                 dut.u_slot_pipe.wb_q.valid}), 32'(0));

    // Random traffic over a small register set to provoke collisions.
    for (int i = 0; i < 500; i++) begin
      RESET           = ($urandom_range(0, 59) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_dest         = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_reg_write    = 1'($urandom_range(0, 1));
      id_load         = ($urandom_range(0, 2) == 0);
      id_needs_early  = ($urandom_range(0, 3) == 0);
      id_branch_taken = 1'($urandom_range(0, 1));
      id_muldiv_start = ($urandom_range(0, 7) == 0);
      id_hilo_read    = ($urandom_range(0, 5) == 0);
      mem_busy        = ($urandom_range(0, 4) == 0);
      step("rand");
      check("rand_md_cnt", 32'(dut.md_cnt_q), 32'(md_left));
      check("rand_exe_slot", 32'(dut.u_slot_pipe.exe_q), 32'(hist[0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
